// File: rtl/fpmult_pkg.sv
// Shared constants and types for the FP32 multiplier back end (normalise, round, pack).
package fpmult_pkg;

  localparam logic [9:0]  BIAS    = 10'd127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_INF = 8'hFF;

  // InputExc bit positions: {anyExc, ANaN, BNaN, AInf, BInf}
  localparam int EXC_ANY  = 4;
  localparam int EXC_ANAN = 3;
  localparam int EXC_BNAN = 2;
  localparam int EXC_AINF = 1;
  localparam int EXC_BINF = 0;

  // Flags bit positions: {invalid, overflow, underflow, inexact}
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UDF = 1;
  localparam int FLG_INX = 0;

  // Stage-1 register contents; e is a 10-bit two's-complement exponent.
  // exc keeps only the per-operand bits; anyExc carries no extra information here.
  typedef struct packed {
    logic        s;
    logic [9:0]  e;
    logic        zero;
    logic        ea_zero;
    logic        eb_zero;
    logic [22:0] m;
    logic        g;
    logic        st;
    logic [3:0]  exc;
  } s1_t;

endpackage

// File: rtl/fpmult_round_pack.sv
// Stage-2 combinational logic: round-to-nearest-even, then priority-select the packed result.
module fpmult_round_pack
  import fpmult_pkg::*;
(
  input  s1_t         s1_i,
  output logic [31:0] z_o,
  output logic [3:0]  flags_o
);

  logic        up;
  logic [23:0] m_inc;
  logic [9:0]  e_r;
  logic        inf_times_zero;
  logic        is_nan;
  logic        is_inf;

  // A carry out of the mantissa leaves m_inc[22:0] all-zero, so only E needs fixing.
  assign up     = s1_i.g & (s1_i.st | s1_i.m[0]);
  assign m_inc  = {1'b0, s1_i.m} + 24'(up);
  assign e_r    = s1_i.e + (m_inc[23] ? 10'd1 : 10'd0);

  assign inf_times_zero = (s1_i.exc[EXC_AINF] & s1_i.eb_zero) |
                          (s1_i.exc[EXC_BINF] & s1_i.ea_zero);
  assign is_nan = s1_i.exc[EXC_ANAN] | s1_i.exc[EXC_BNAN] | inf_times_zero;
  assign is_inf = s1_i.exc[EXC_AINF] | s1_i.exc[EXC_BINF];

  always_comb begin
    z_o     = {s1_i.s, e_r[7:0], m_inc[22:0]};
    flags_o = 4'b0000;
    if (is_nan) begin
      z_o              = QNAN;
      flags_o[FLG_INV] = inf_times_zero;
    end else if (is_inf) begin
      z_o = {s1_i.s, EXP_INF, 23'h0};
    end else if (s1_i.zero) begin
      z_o = {s1_i.s, 31'h0};
    end else if ($signed(e_r) >= $signed(10'd255)) begin
      z_o              = {s1_i.s, EXP_INF, 23'h0};
      flags_o[FLG_OVF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end else if ($signed(e_r) <= $signed(10'd0)) begin
      z_o              = {s1_i.s, 31'h0};
      flags_o[FLG_UDF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end else begin
      flags_o[FLG_INX] = s1_i.g | s1_i.st;
    end
  end

endmodule

// File: rtl/fpmult_norm_round.sv
// FP32 multiplier back end: 2-stage valid/ready pipeline producing the packed product and flags.
module fpmult_norm_round
  import fpmult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Sa,
  input  logic        Sb,
  input  logic [7:0]  Ea,
  input  logic [7:0]  Eb,
  input  logic [47:0] Mp,
  input  logic [4:0]  InputExc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Z,
  output logic [3:0]  Flags
);

  // Handshake: a stage transfers on valid & ready; a full stage may refill in the
  // same cycle it drains, so ready ripples back combinationally from out_ready.
  s1_t         s1_d, s1_q;
  logic        s1_valid_q, s2_valid_q;
  logic        s2_ready;
  logic [31:0] z_q, rp_z;
  logic [3:0]  flags_q, rp_flags;
  logic [9:0]  e_base;
  logic        unused_any;

  assign unused_any = InputExc[EXC_ANY];
  assign s2_ready   = ~s2_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_ready;
  assign e_base     = {2'b00, Ea} + {2'b00, Eb} - BIAS;

  always_comb begin
    s1_d         = '0;
    s1_d.s       = Sa ^ Sb;
    s1_d.ea_zero = (Ea == 8'h00);
    s1_d.eb_zero = (Eb == 8'h00);
    s1_d.zero    = s1_d.ea_zero | s1_d.eb_zero;
    s1_d.exc     = InputExc[3:0];
    if (Mp[47]) begin
      s1_d.m  = Mp[46:24];
      s1_d.g  = Mp[23];
      s1_d.st = |Mp[22:0];
      s1_d.e  = e_base + 10'd1;
    end else begin
      s1_d.m  = Mp[45:23];
      s1_d.g  = Mp[22];
      s1_d.st = |Mp[21:0];
      s1_d.e  = e_base;
    end
  end

  fpmult_round_pack u_round_pack (
    .s1_i    (s1_q),
    .z_o     (rp_z),
    .flags_o (rp_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      z_q        <= '0;
      flags_q    <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          z_q     <= rp_z;
          flags_q <= rp_flags;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign Z         = z_q;
  assign Flags     = flags_q;

endmodule

// File: tb/tb_fpmult_norm_round.sv
// Self-checking bench for fpmult_norm_round: directed vectors, backpressure, reset flush.
module tb_fpmult_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Sa, Sb;
  logic [7:0]  Ea, Eb;
  logic [47:0] Mp;
  logic [4:0]  InputExc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;
  logic [3:0]  Flags;

  logic [35:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;

  fpmult_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sa        (Sa),
    .Sb        (Sb),
    .Ea        (Ea),
    .Eb        (Eb),
    .Mp        (Mp),
    .InputExc  (InputExc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .Flags     (Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [47:0] mp, input logic [4:0] exc,
                      input logic [31:0] z, input logic [3:0] f, input bit push);
    int waited = 0;
    Sa = sa; Sb = sb; Ea = ea; Eb = eb; Mp = mp; InputExc = exc;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {35'h0, in_ready}, 36'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    accepted++;
    if (push) exp_q.push_back({z, f});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_all();
    send(0, 0, 127, 127, 48'h900000000000, 5'b00000, 32'h40100000, 4'b0000, 1);
    send(0, 0, 128, 128, 48'h600000000000, 5'b00000, 32'h40C00000, 4'b0000, 1);
    send(0, 0, 127, 127, 48'h400000400000, 5'b00000, 32'h3F800000, 4'b0001, 1);
    send(0, 0, 127, 127, 48'h400000C00000, 5'b00000, 32'h3F800002, 4'b0001, 1);
    send(0, 1, 127, 127, 48'h800000800000, 5'b00000, 32'hC0000000, 4'b0001, 1);
    send(0, 0, 254, 254, 48'h400000000000, 5'b00000, 32'h7F800000, 4'b0101, 1);
    send(1, 0, 254, 254, 48'h400000000000, 5'b00000, 32'hFF800000, 4'b0101, 1);
    send(0, 0,   1,   1, 48'h400000000000, 5'b00000, 32'h00000000, 4'b0011, 1);
    send(0, 0, 255,   0, 48'h000000000000, 5'b10010, 32'h7FC00000, 4'b1000, 1);
    send(0, 0, 255, 130, 48'h400000000000, 5'b10010, 32'h7F800000, 4'b0000, 1);
    send(0, 0, 255, 127, 48'h000000000000, 5'b11000, 32'h7FC00000, 4'b0000, 1);
    send(1, 0, 128, 128, 48'h600000000000, 5'b00000, 32'hC0C00000, 4'b0000, 1);
    send(0, 0, 254, 127, 48'h7FFFFFFFFFFF, 5'b00000, 32'h7F800000, 4'b0101, 1);
    send(0, 0, 254, 127, 48'h7FFFFF800000, 5'b00000, 32'h7F7FFFFF, 4'b0000, 1);
    send(0, 0,  63,  64, 48'h400000000000, 5'b00000, 32'h00000000, 4'b0011, 1);
    send(0, 0,  63,  64, 48'h800000000000, 5'b00000, 32'h00800000, 4'b0000, 1);
    send(0, 0, 127, 127, 48'h7FFFFFFFFFFF, 5'b00000, 32'h40000000, 4'b0001, 1);
    send(1, 0,   0, 130, 48'h400000000000, 5'b00000, 32'h80000000, 4'b0000, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 36'(exp_q.size()), 36'h0);
  endtask

  // Scoreboard: an output seen at a negedge with out_ready high transfers at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 36'(exp_q.size()), 36'h1);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("z", {4'h0, Z}, {4'h0, e[35:4]});
        check("flags", {32'h0, Flags}, {32'h0, e[3:0]});
      end
    end
  end

  initial begin
    bit done = 0;
    logic [31:0] z_hold;
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Sa = 0; Sb = 0; Ea = 0; Eb = 0; Mp = '0; InputExc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {35'h0, out_valid}, 36'h0);
    check("rst_z", {4'h0, Z}, 36'h0);
    check("rst_flags", {32'h0, Flags}, 36'h0);
    check("rst_in_ready", {35'h0, in_ready}, 36'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: result visible exactly two edges after acceptance.
    send(0, 0, 127, 127, 48'h900000000000, 5'b00000, 32'h40100000, 4'b0000, 1);
    @(negedge clk);
    check("lat_1cyc", {35'h0, out_valid}, 36'h0);
    @(negedge clk);
    check("lat_2cyc", {35'h0, out_valid}, 36'h1);
    @(posedge clk); #1;
    drain();

    send_all();
    drain();

    // Backpressure: two held, then in_ready drops and the output stays put.
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = accepted;
    fork
      begin
        send(0, 0, 128, 128, 48'h600000000000, 5'b00000, 32'h40C00000, 4'b0000, 1);
        send(0, 0, 127, 127, 48'h400000C00000, 5'b00000, 32'h3F800002, 4'b0001, 1);
        send(0, 0, 254, 254, 48'h400000000000, 5'b00000, 32'h7F800000, 4'b0101, 1);
        send(0, 0,   1,   1, 48'h400000000000, 5'b00000, 32'h00000000, 4'b0011, 1);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_held", 36'(accepted - base), 36'h2);
        check("bp_in_ready", {35'h0, in_ready}, 36'h0);
        check("bp_out_valid", {35'h0, out_valid}, 36'h1);
        z_hold = Z;
        repeat (2) @(negedge clk);
        check("bp_z_stable", {4'h0, Z}, {4'h0, z_hold});
        check("bp_in_ready2", {35'h0, in_ready}, 36'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random backpressure over the whole vector set.
    fork
      begin
        send_all();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with both stages full drops everything in flight.
    out_ready = 1'b0;
    send(0, 0, 128, 128, 48'h600000000000, 5'b00000, 32'h0, 4'h0, 0);
    send(0, 0, 127, 127, 48'h900000000000, 5'b00000, 32'h0, 4'h0, 0);
    check("pre_rst_out_valid", {35'h0, out_valid}, 36'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_out_valid", {35'h0, out_valid}, 36'h0);
    check("post_rst_in_ready", {35'h0, in_ready}, 36'h1);
    check("post_rst_z", {4'h0, Z}, 36'h0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_out", {35'h0, out_valid}, 36'h0);
    send(0, 1, 127, 127, 48'h400000400000, 5'b00000, 32'hBF800000, 4'b0001, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
